// File: rtl/stack_unit_if.sv
// Push/pop strobe and status bundle between the control path / ALU and stack_unit.
interface stack_unit_if #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
);
  logic          push;
  logic          pop;
  logic [15:0]   din;
  logic [15:0]   stackout;
  logic [AW:0]   sp;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;

  modport master (
    output push, pop, din,
    input  stackout, sp, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop, din,
    output stackout, sp, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_unit.sv
// LIFO stack for PSH/POP: registered top-of-stack, saturating pointer, sticky error flags.
module stack_unit #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  stack_unit_if.slave   bus
);

  localparam int unsigned DW  = 16;
  localparam int unsigned SPW = AW + 1;

  localparam logic [SPW-1:0] SP_ZERO = '0;
  localparam logic [SPW-1:0] SP_ONE  = SPW'(1);
  localparam logic [SPW-1:0] SP_TWO  = SPW'(2);
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  logic [DW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [DW-1:0]  top_q, top_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           empty_q, full_q;

  logic           wr_en;
  logic [AW-1:0]  wr_addr;
  logic [AW-1:0]  rd_addr;
  logic           is_empty, is_full;

  assign is_empty = (sp_q == SP_ZERO);
  assign is_full  = (sp_q == SP_FULL);
  // Entry that becomes the new top after a pop (only meaningful when sp >= 2).
  assign rd_addr  = AW'(sp_q - SP_TWO);

  // Next-state decode of the push/pop strobes.
  always_comb begin
    sp_d    = sp_q;
    top_d   = top_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    wr_en   = 1'b0;
    wr_addr = '0;
    unique case ({bus.push, bus.pop})
      2'b10: begin
        if (is_full) begin
          ovf_d = 1'b1;
        end else begin
          wr_en   = 1'b1;
          wr_addr = AW'(sp_q);
          sp_d    = sp_q + SP_ONE;
          top_d   = bus.din;
        end
      end
      2'b01: begin
        if (is_empty) begin
          unf_d = 1'b1;
        end else begin
          sp_d  = sp_q - SP_ONE;
          top_d = (sp_q >= SP_TWO) ? mem_q[rd_addr] : '0;
        end
      end
      2'b11: begin
        wr_en = 1'b1;
        top_d = bus.din;
        if (is_empty) begin
          // Nothing to replace: behaves as a push but records the refused pop.
          wr_addr = '0;
          sp_d    = SP_ONE;
          unf_d   = 1'b1;
        end else begin
          wr_addr = AW'(sp_q - SP_ONE);
        end
      end
      default: ;
    endcase
  end

  // Pointer, top-of-stack mirror, status decodes and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      sp_q    <= '0;
      top_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      top_q   <= top_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      empty_q <= (sp_d == SP_ZERO);
      full_q  <= (sp_d == SP_FULL);
    end
  end

  // Storage array; contents are not reset and never read while empty.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem_q[wr_addr] <= bus.din;
    end
  end

  assign bus.stackout  = top_q;
  assign bus.sp        = sp_q;
  assign bus.empty     = empty_q;
  assign bus.full      = full_q;
  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit: ordering, boundaries, simultaneous strobes, reset priority.
module tb_stack_unit;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  stack_unit_if #(.DEPTH(DEPTH), .AW(AW)) bus ();

  stack_unit #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of strobes, then sample 1 time unit after the edge.
  task automatic cycle(input logic p, input logic q, input logic [15:0] d);
    bus.push = p;
    bus.pop  = q;
    bus.din  = d;
    @(posedge clk);
    #1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cycle(1'b0, 1'b0, 16'h0000);
    reset = 1'b0;
  endtask

  task automatic check_state(input string tag, input int sp, input logic [15:0] top,
                             input logic ovf, input logic unf);
    check({tag, ".sp"},    32'(bus.sp),        32'(sp));
    check({tag, ".top"},   32'(bus.stackout),  32'(top));
    check({tag, ".empty"}, 32'(bus.empty),     32'(sp == 0));
    check({tag, ".full"},  32'(bus.full),      32'(sp == DEPTH));
    check({tag, ".ovf"},   32'(bus.overflow),  32'(ovf));
    check({tag, ".unf"},   32'(bus.underflow), 32'(unf));
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    bus.din  = 16'h0000;

    // Reset wins over a simultaneous push
    cycle(1'b1, 1'b0, 16'hBEEF);
    check_state("reset", 0, 16'h0000, 1'b0, 1'b0);
    reset = 1'b0;

    // Push/pop ordering, back to back
    cycle(1'b1, 1'b0, 16'h0001); check_state("push1", 1, 16'h0001, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0002); check_state("push2", 2, 16'h0002, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0003); check_state("push3", 3, 16'h0003, 1'b0, 1'b0);
    // Pre-pop top is visible during the pop cycle
    bus.pop = 1'b1;
    #1;
    check("prepop.top", 32'(bus.stackout), 32'h0003);
    cycle(1'b0, 1'b1, 16'h0000); check_state("pop1", 2, 16'h0002, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000); check_state("pop2", 1, 16'h0001, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000); check_state("pop3", 0, 16'h0000, 1'b0, 1'b0);

    // Empty boundary
    do_reset();
    cycle(1'b0, 1'b1, 16'h0000); check_state("under", 0, 16'h0000, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, 16'h00AA); check_state("under_push", 1, 16'h00AA, 1'b0, 1'b1);

    // Full boundary
    do_reset();
    for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 16'h1000 + 16'(i));
    check_state("fill", 16, 16'h100F, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'hFFFF); check_state("over", 16, 16'h100F, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000); check_state("over_pop", 15, 16'h100E, 1'b1, 1'b0);

    // Replace top while full
    cycle(1'b1, 1'b0, 16'h2000); check_state("refill", 16, 16'h2000, 1'b1, 1'b0);
    cycle(1'b1, 1'b1, 16'h5555); check_state("repl_full", 16, 16'h5555, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000); check_state("repl_pop", 15, 16'h100E, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000); check_state("repl_pop2", 14, 16'h100D, 1'b1, 1'b0);

    // Replace top mid-stack, then pop shows the entry beneath
    cycle(1'b1, 1'b1, 16'h6666); check_state("repl_mid", 14, 16'h6666, 1'b1, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000); check_state("repl_mid_pop", 13, 16'h100C, 1'b1, 1'b0);

    // Push+pop on an empty stack
    do_reset();
    cycle(1'b1, 1'b1, 16'h7777); check_state("pp_empty", 1, 16'h7777, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 16'h0000); check_state("pp_empty_pop", 0, 16'h0000, 1'b0, 1'b1);

    // Reset mid-operation, with a push strobe held during reset
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 16'h0A00 + 16'(i));
    check_state("five", 5, 16'h0A04, 1'b0, 1'b0);
    reset = 1'b1;
    cycle(1'b1, 1'b0, 16'h9999);
    reset = 1'b0;
    check_state("mid_reset", 0, 16'h0000, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 16'h0042); check_state("after_reset", 1, 16'h0042, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 16'h0000); check_state("after_reset_pop", 0, 16'h0000, 1'b0, 1'b0);

    // Idle holds state
    cycle(1'b1, 1'b0, 16'h1234);
    cycle(1'b0, 1'b0, 16'hDEAD); check_state("idle", 1, 16'h1234, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
